// File: rtl/alu_exec_if.sv
// Request/result handshake bundle for alu_exec_unit.
// The master drives requests and consumes results; the slave is the ALU.
interface alu_exec_if #(
  parameter int WIDTH = 32
) ();
  logic             inValid;
  logic             inReady;
  logic [3:0]       aluCtr;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] aluRes;
  logic             zero;
  logic             overflow;
  logic             illegalOp;
  logic             busy;

  modport master (
    output inValid, aluCtr, srcA, srcB, outReady,
    input  inReady, outValid, aluRes, zero, overflow, illegalOp, busy
  );

  modport slave (
    input  inValid, aluCtr, srcA, srcB, outReady,
    output inReady, outValid, aluRes, zero, overflow, illegalOp, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with registered result and valid/ready on both sides.
// Define ALU_EXEC_MULT_EN to add the iterative shift-add multiplier (code 1000).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             ill;
  } op_t;

`ifdef ALU_EXEC_MULT_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CNT_W  = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_MUL = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_single;
  op_t              w_op;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ovf;
  logic             r_ill;

  function automatic op_t alu_op(input logic [3:0] code,
                                 input logic signed [WIDTH-1:0] a,
                                 input logic signed [WIDTH-1:0] b);
    op_t                     r;
    logic signed [WIDTH-1:0] s;
    r = '0;
    s = '0;
    case (code)
      OP_ADD: begin
        s     = a + b;
        r.res = s;
        r.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s     = a - b;
        r.res = s;
        r.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_SLT:  r.res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  assign w_accept = bus.inValid & w_in_ready;
  assign w_op     = alu_op(bus.aluCtr, bus.srcA, bus.srcB);

`ifdef ALU_EXEC_MULT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             w_is_mul;
  logic             w_last;
  logic [WIDTH-1:0] w_prod;

  assign w_is_mul = (bus.aluCtr == OP_MUL);
  assign w_single = w_accept & ~w_is_mul;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // Partial product including the bit consumed this cycle; on the last
  // iteration this is already the final truncated product.
  assign w_prod   = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= bus.srcA;
      r_mplier <= bus.srcB;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= w_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign w_single = w_accept;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
`ifdef ALU_EXEC_MULT_EN
    if (r_state == S_MUL) w_next = w_last ? S_DONE : S_MUL;
    else
`endif
    if (w_accept) begin
`ifdef ALU_EXEC_MULT_EN
      w_next = w_is_mul ? S_MUL : S_DONE;
`else
      w_next = S_DONE;
`endif
    end else if (r_state == S_DONE && bus.outReady) begin
      w_next = S_IDLE;
    end
  end

  always_comb begin
    w_in_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.outReady);
    bus.inReady   = w_in_ready;
    bus.outValid  = (r_state == S_DONE);
`ifdef ALU_EXEC_MULT_EN
    bus.busy      = (r_state == S_MUL);
`else
    bus.busy      = 1'b0;
`endif
    bus.aluRes    = r_res;
    bus.zero      = r_zero;
    bus.overflow  = r_ovf;
    bus.illegalOp = r_ill;
  end

  // Result stage: flags are captured with the result so they stay coherent under stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_res  <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_ill  <= 1'b0;
    end else if (w_single) begin
      r_res  <= w_op.res;
      r_zero <= (w_op.res == '0);
      r_ovf  <= w_op.ovf;
      r_ill  <= w_op.ill;
    end
`ifdef ALU_EXEC_MULT_EN
    else if (r_state == S_MUL && w_last) begin
      r_res  <= w_prod;
      r_zero <= (w_prod == '0);
      r_ovf  <= 1'b0;
      r_ill  <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: request-level model with an in-order
// result queue, plus hand-computed expectations for the key scenarios.
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_MUL = 4'b1000;
  localparam logic [3:0] C_BAD = 4'b1111;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset;

  alu_exec_if #(.WIDTH(W)) bus ();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        ill;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = 32'd0;
    e.o   = 1'b0;
    e.ill = 1'b0;
    case (c)
      C_ADD: begin r = sa + sb; e.res = r[31:0]; e.o = (r > S_MAX) || (r < S_MIN); end
      C_SUB: begin r = sa - sb; e.res = r[31:0]; e.o = (r > S_MAX) || (r < S_MIN); end
      C_AND: e.res = a & b;
      C_OR:  e.res = a | b;
      C_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_MULT_EN
      C_MUL: begin p = 64'(a) * 64'(b); e.res = p[31:0]; end
`endif
      default: begin p = 64'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Outputs are compared while valid; the head leaves the queue on transfer.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      q.delete();
    end else begin
      if (bus.outValid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got outValid=1 aluRes=0x%0h required no pending result", bus.aluRes);
        end else begin
          chk("model_aluRes", bus.aluRes, q[0].res);
          chk("model_zero", bus.zero, q[0].z);
          chk("model_overflow", bus.overflow, q[0].o);
          chk("model_illegalOp", bus.illegalOp, q[0].ill);
          if (bus.outReady) void'(q.pop_front());
        end
      end
      if (bus.inValid && bus.inReady === 1'b1) q.push_back(model(bus.aluCtr, bus.srcA, bus.srcB));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    bus.aluCtr  = c;
    bus.srcA    = a;
    bus.srcB    = b;
    bus.inValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.inReady === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: got inReady=0 for 100 cycles required 1");
    end
    step();
    bus.inValid = 1'b0;
  endtask

  initial begin
    bit seen;
    reset        = 1'b0;
    bus.inValid  = 1'b1;
    bus.aluCtr   = C_ADD;
    bus.srcA     = 32'd1;
    bus.srcB     = 32'd2;
    bus.outReady = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outValid", bus.outValid, 1'b0);
    chk("rst_aluRes", bus.aluRes, 32'd0);
    chk("rst_flags", {bus.zero, bus.overflow, bus.illegalOp, bus.busy}, 4'b0000);
    step();
    reset        = 1'b1;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clk);
    chk("rst_inReady_after", bus.inReady, 1'b1);
    step();

    send(C_ADD, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    chk("add_ovf_valid", bus.outValid, 1'b1);
    chk("add_ovf_res", bus.aluRes, 32'h8000_0000);
    chk("add_ovf_flag", bus.overflow, 1'b1);
    chk("add_ovf_zero", bus.zero, 1'b0);
    step();

    send(C_SUB, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub_res", bus.aluRes, 32'd0);
    chk("sub_zero", bus.zero, 1'b1);
    chk("sub_ovf", bus.overflow, 1'b0);
    step();

    send(C_SUB, 32'h8000_0000, 32'd1);
    @(negedge clk);
    chk("sub_ovf_res", bus.aluRes, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", bus.overflow, 1'b1);
    step();

    send(C_SLT, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("slt_neg_lt", bus.aluRes, 32'd1);
    step();
    send(C_SLT, 32'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("slt_swapped", bus.aluRes, 32'd0);
    step();

    send(C_BAD, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    chk("illegal_flag", bus.illegalOp, 1'b1);
    chk("illegal_res", bus.aluRes, 32'd0);
    chk("illegal_zero", bus.zero, 1'b1);
    step();

    bus.outReady = 1'b0;
    send(C_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    bus.inValid = 1'b1;
    bus.aluCtr  = C_OR;
    bus.srcA    = 32'h0000_F0F0;
    bus.srcB    = 32'h0000_0FF0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_res", bus.aluRes, 32'h0000_00F0);
      chk("bp_inReady", bus.inReady, 1'b0);
    end
    step();
    bus.outReady = 1'b1;
    @(negedge clk);
    chk("bp_release_inReady", bus.inReady, 1'b1);
    step();
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", bus.outValid, 1'b1);
    chk("bp_second_res", bus.aluRes, 32'h0000_FFF0);
    step();

    for (int i = 0; i < 8; i++) begin
      bus.inValid = 1'b1;
      bus.aluCtr  = C_ADD;
      bus.srcA    = 32'(i) * 32'h1111_1111;
      bus.srcB    = 32'h7000_0000;
      @(negedge clk);
      if (i > 0) chk("stream_valid", bus.outValid, 1'b1);
      chk("stream_inReady", bus.inReady, 1'b1);
      step();
    end
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("stream_last_res", bus.aluRes, 32'hE777_7777);
    chk("stream_last_ovf", bus.overflow, 1'b1);
    step();

    send(C_MUL, 32'd7, 32'd6);
`ifdef ALU_EXEC_MULT_EN
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_busy", bus.busy, 1'b1);
      chk("mul_inReady", bus.inReady, 1'b0);
    end
    @(negedge clk);
    chk("mul_valid", bus.outValid, 1'b1);
    chk("mul_res", bus.aluRes, 32'd42);
    step();

    send(C_MUL, 32'd7, 32'd6);
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("mul_rst_busy", bus.busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.outValid === 1'b1) seen = 1'b1;
    end
    chk("mul_rst_no_output", seen, 1'b0);
    chk("mul_rst_idle_ready", bus.inReady, 1'b1);
    step();
`else
    @(negedge clk);
    chk("mul_off_valid", bus.outValid, 1'b1);
    chk("mul_off_illegal", bus.illegalOp, 1'b1);
    chk("mul_off_res", bus.aluRes, 32'd0);
    chk("mul_off_busy", bus.busy, 1'b0);
    step();
    seen = 1'b0;
`endif

    repeat (3) step();
    @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_outValid", bus.outValid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
